// File: rtl/recognition_result_uart_tx.sv
// recognition_result_uart_tx
//   Sends each speaker-recognition result to the host as the ASCII line
//   "ID:n\r\n" on an 8N1 UART. One further result may wait in a pending slot
//   while a line is in flight. A newer result replaces a waiting one and sets
//   the sticky overrun flag.
//
// Ports
//   clk                     system clock
//   rst                     synchronous, active-high reset
//   recognition_result[2:0] speaker index 0..6, or NO_RESULT_CODE (sent as 'X')
//   recognition_result_flag one-cycle strobe; the code is valid in the same cycle
//   uart_tx                 serial output, idle high (registered)
//   tx_busy                 high while a line is in flight, including queued lines
//   msg_done                one-cycle pulse when the stop bit of the final 0x0A ends
//   overrun                 sticky; a pending result was overwritten
//   dbg_state[2:0]          current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: there is no back-pressure. A strobe is always accepted. It starts
// a line when the FSM is idle or the last stop bit ends in that cycle, and
// otherwise it fills the pending slot.
module recognition_result_uart_tx #(
  parameter int         CLK_FREQ       = 50_000_000,
  parameter int         BAUD_RATE      = 115200,
  parameter int         CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE,
  parameter logic [2:0] NO_RESULT_CODE = 3'b111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] recognition_result,
  input  logic       recognition_result_flag,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       msg_done,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  // NEXT is resolved combinationally at the end of STOP and is never registered.
  // This keeps the start bit of the following byte directly after the stop bit.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t        r_state, w_state_n;
  logic [BW-1:0] r_baud, w_baud_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [2:0]    r_byte, w_byte_n;
  logic [2:0]    r_code, w_code_n;
  logic [2:0]    r_pend_code, w_pend_code_n;
  logic          r_pend_valid, w_pend_valid_n;
  logic          r_overrun, w_overrun_n;
  logic          r_tx, w_tx_n;
  logic          r_busy;
  logic          r_done, w_done_n;
  logic          w_baud_done;
  logic          w_line_start;
  logic [7:0]    w_tx_byte;

  function automatic logic [7:0] f_line_byte(input logic [2:0] idx, input logic [2:0] code);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h49;
      3'd1:    b = 8'h44;
      3'd2:    b = 8'h3A;
      3'd3:    b = (code == NO_RESULT_CODE) ? 8'h58 : (8'h30 + {5'b0, code});
      3'd4:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  assign w_baud_done = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_n    = r_state;
    w_baud_n     = r_baud;
    w_bit_n      = r_bit;
    w_byte_n     = r_byte;
    w_done_n     = 1'b0;
    w_line_start = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (recognition_result_flag || r_pend_valid) w_line_start = 1'b1;
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_n = S_DATA;
          w_baud_n  = '0;
          w_bit_n   = 3'd0;
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) w_state_n = S_STOP;
          else               w_bit_n   = r_bit + 3'd1;
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_n = '0;
          // This branch is the NEXT decision.
          if (r_byte != 3'd5) begin
            w_byte_n  = r_byte + 3'd1;
            w_state_n = S_START;
          end else begin
            w_done_n = 1'b1;
            if (recognition_result_flag || r_pend_valid) w_line_start = 1'b1;
            else                                         w_state_n    = S_IDLE;
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_line_start) begin
      w_state_n = S_START;
      w_baud_n  = '0;
      w_bit_n   = 3'd0;
      w_byte_n  = 3'd0;
    end
  end

  // Result capture. A strobe arriving when a line starts is sent at once. It
  // still counts as an overrun if it displaces a result that was waiting.
  always_comb begin
    w_code_n       = r_code;
    w_pend_code_n  = r_pend_code;
    w_pend_valid_n = r_pend_valid;
    w_overrun_n    = r_overrun;
    if (w_line_start) begin
      w_pend_valid_n = 1'b0;
      if (recognition_result_flag) begin
        w_code_n = recognition_result;
        if (r_pend_valid) w_overrun_n = 1'b1;
      end else begin
        w_code_n = r_pend_code;
      end
    end else if (recognition_result_flag) begin
      w_pend_code_n  = recognition_result;
      w_pend_valid_n = 1'b1;
      if (r_pend_valid) w_overrun_n = 1'b1;
    end
  end

  // The serial output is computed from the next state, so uart_tx is a clean
  // flop output aligned with the state register.
  always_comb begin
    w_tx_byte = f_line_byte(w_byte_n, w_code_n);
    case (w_state_n)
      S_START: w_tx_n = 1'b0;
      S_DATA:  w_tx_n = w_tx_byte[w_bit_n];
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit        <= 3'd0;
      r_byte       <= 3'd0;
      r_code       <= 3'd0;
      r_pend_code  <= 3'd0;
      r_pend_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_baud       <= w_baud_n;
      r_bit        <= w_bit_n;
      r_byte       <= w_byte_n;
      r_code       <= w_code_n;
      r_pend_code  <= w_pend_code_n;
      r_pend_valid <= w_pend_valid_n;
      r_overrun    <= w_overrun_n;
      r_tx         <= w_tx_n;
      r_busy       <= (w_state_n != S_IDLE);
      r_done       <= w_done_n;
    end
  end

  assign uart_tx   = r_tx;
  assign tx_busy   = r_busy;
  assign msg_done  = r_done;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_recognition_result_uart_tx.sv
// Bench for recognition_result_uart_tx, with CLKS_PER_BIT = 8.
// Inputs change on falling edges. "Index k" means the falling edge k cycles
// after the clock edge that samples a line's strobe.
module tb_recognition_result_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] res;
  logic       flag;
  logic       uart_tx, tx_busy, msg_done, overrun;
  logic [2:0] dbg_state;

  recognition_result_uart_tx #(
    .CLK_FREQ      (8),
    .BAUD_RATE     (1),
    .NO_RESULT_CODE(3'b111)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .recognition_result     (res),
    .recognition_result_flag(flag),
    .uart_tx                (uart_tx),
    .tx_busy                (tx_busy),
    .msg_done               (msg_done),
    .overrun                (overrun),
    .dbg_state              (dbg_state)
  );

  // clock / monitors
  always #5 clk = ~clk;

  int cyc = 0, md_count = 0, md_cyc = 0, busy_cnt = 0, t0 = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (msg_done === 1'b1) begin
      md_count = md_count + 1;
      md_cyc   = cyc;
    end
    if (tx_busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  // scoreboard
  int         total = 0, bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_bytes[6];
  int         rx_frame_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic start_line(input logic [2:0] code);
    @(negedge clk);
    md_count = 0;
    busy_cnt = 0;
    flag = 1'b1;
    res  = code;
    @(negedge clk);
    flag = 1'b0;
    t0   = cyc;
    chk("latency_tx", {31'b0, uart_tx}, 32'd0);
    chk("latency_busy", {31'b0, tx_busy}, 32'd1);
  endtask

  // Waits n falling edges, then holds a strobe for one cycle.
  task automatic pulse_after(input int n, input logic [2:0] code);
    repeat (n - 1) @(negedge clk);
    flag = 1'b1;
    res  = code;
    @(negedge clk);
    flag = 1'b0;
  endtask

  // Entered at the middle of the line's first start bit. Returns at the middle
  // of its last stop bit.
  task automatic rx_line();
    int b, p;
    rx_frame_err = 0;
    for (int j = 0; j < 60; j++) begin
      b = j / 10;
      p = j % 10;
      if (p == 0)      begin if (uart_tx !== 1'b0) rx_frame_err++; end
      else if (p == 9) begin if (uart_tx !== 1'b1) rx_frame_err++; end
      else             rx_bytes[b][p-1] = uart_tx;
      if (j < 59) repeat (8) @(negedge clk);
    end
  endtask

  task automatic check_line(input logic [7:0] digit, input string tag);
    logic [7:0] e;
    exp_q.push_back(8'h49);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h3A);
    exp_q.push_back(digit);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    for (int b = 0; b < 6; b++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_byte%0d", tag, b), {24'b0, rx_bytes[b]}, {24'b0, e});
    end
    chk($sformatf("%s_framing", tag), rx_frame_err, 32'd0);
  endtask

  // Two lines: the second strobe is sampled n cycles after the first.
  task automatic two_lines(input logic [2:0] c1, input logic [2:0] c2, input int n,
                           input logic [7:0] d1, input logic [7:0] d2, input string tag);
    start_line(c1);
    fork
      begin
        repeat (4) @(negedge clk);
        rx_line();
        check_line(d1, {tag, "_l1"});
        repeat (8) @(negedge clk);
        rx_line();
        check_line(d2, {tag, "_l2"});
      end
      pulse_after(n, c2);
    join
    repeat (8) @(negedge clk);
    chk({tag, "_md_count"}, md_count, 32'd2);
    chk({tag, "_md_cycle"}, md_cyc - t0, 32'd960);
    chk({tag, "_busy_cycles"}, busy_cnt, 32'd960);
    chk({tag, "_busy_end"}, {31'b0, tx_busy}, 32'd0);
    chk({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
  endtask

  typedef struct {
    logic [2:0] code;
    logic [7:0] digit;
  } vec_t;

  vec_t vecs[4];
  int   low_cnt;

  initial begin
    vecs[0] = '{3'd2, 8'h32};
    vecs[1] = '{3'd7, 8'h58};
    vecs[2] = '{3'd0, 8'h30};
    vecs[3] = '{3'd6, 8'h36};

    rst  = 1'b1;
    flag = 1'b0;
    res  = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'b0, uart_tx}, 32'd1);
    chk("reset_busy", {31'b0, tx_busy}, 32'd0);
    chk("reset_msg_done", {31'b0, msg_done}, 32'd0);
    chk("reset_overrun", {31'b0, overrun}, 32'd0);
    chk("reset_state", {29'b0, dbg_state}, 32'd0);

    // A strobe coinciding with reset must be dropped.
    flag = 1'b1;
    res  = 3'd2;
    @(negedge clk);
    flag = 1'b0;
    rst  = 1'b0;
    repeat (3) @(negedge clk);
    chk("strobe_in_reset_busy", {31'b0, tx_busy}, 32'd0);
    chk("strobe_in_reset_tx", {31'b0, uart_tx}, 32'd1);

    // Single lines, table-driven.
    for (int i = 0; i < 4; i++) begin
      start_line(vecs[i].code);
      repeat (4) @(negedge clk);
      rx_line();
      check_line(vecs[i].digit, $sformatf("vec%0d", i));
      repeat (8) @(negedge clk);
      chk($sformatf("vec%0d_md_count", i), md_count, 32'd1);
      chk($sformatf("vec%0d_md_cycle", i), md_cyc - t0, 32'd480);
      chk($sformatf("vec%0d_busy_cycles", i), busy_cnt, 32'd480);
      chk($sformatf("vec%0d_busy_end", i), {31'b0, tx_busy}, 32'd0);
      chk($sformatf("vec%0d_overrun", i), {31'b0, overrun}, 32'd0);
      repeat (20) @(negedge clk);
    end

    // Queued result mid-line, and a strobe landing exactly on the final stop edge.
    two_lines(3'd1, 3'd5, 100, 8'h31, 8'h35, "queued");
    repeat (20) @(negedge clk);
    two_lines(3'd3, 3'd5, 480, 8'h33, 8'h35, "boundary");
    repeat (20) @(negedge clk);

    // Overrun: code 3 waits, then code 4 replaces it.
    start_line(3'd1);
    fork
      begin
        repeat (4) @(negedge clk);
        rx_line();
        check_line(8'h31, "ovr_l1");
        repeat (8) @(negedge clk);
        rx_line();
        check_line(8'h34, "ovr_l2");
      end
      begin
        pulse_after(50, 3'd3);
        chk("ovr_after_first_pending", {31'b0, overrun}, 32'd0);
        pulse_after(10, 3'd4);
        chk("ovr_set", {31'b0, overrun}, 32'd1);
      end
    join
    repeat (8) @(negedge clk);
    chk("ovr_md_count", md_count, 32'd2);
    chk("ovr_sticky", {31'b0, overrun}, 32'd1);
    chk("ovr_busy_end", {31'b0, tx_busy}, 32'd0);
    repeat (20) @(negedge clk);

    // Reset mid-line.
    start_line(3'd0);
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_tx", {31'b0, uart_tx}, 32'd1);
    chk("midreset_busy", {31'b0, tx_busy}, 32'd0);
    chk("midreset_overrun", {31'b0, overrun}, 32'd0);
    chk("midreset_state", {29'b0, dbg_state}, 32'd0);
    low_cnt = 0;
    repeat (600) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low_cnt++;
    end
    chk("midreset_line_quiet", low_cnt, 32'd0);
    chk("midreset_busy_quiet", {31'b0, tx_busy}, 32'd0);

    // The code is latched at the strobe. Input noise afterwards is ignored.
    start_line(3'd6);
    fork
      begin
        repeat (4) @(negedge clk);
        rx_line();
        check_line(8'h36, "latched");
      end
      begin
        repeat (480) begin
          res = 3'($urandom_range(0, 7));
          @(negedge clk);
        end
      end
    join
    repeat (8) @(negedge clk);
    chk("latched_md_count", md_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
